mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data access) arbiter in front of a
// single-port synchronous RAM with one cycle of read latency.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   i_req/i_addr                fetch request and byte address
//   i_rdata/i_ready             fetched word (held between fetches), completion pulse
//   d_req/d_we/d_addr/d_wdata   data request, write select, byte address, write data
//   d_rdata/d_ready             read data (held between reads), completion pulse
//   mem_addr/mem_wdata/mem_we   RAM word address, write data, write enable
//   mem_rdata                   RAM read data, valid the cycle after issue
//   busy                        high while a transaction is in its RAM latency cycle
module mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {StIdle, StWait} state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic                r_last_grant_d;  // 1: last grant went to the data port
    logic                r_wait_d;        // port owning the outstanding transaction
    logic                r_wait_we;       // outstanding transaction is a write
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_i_hold;
    logic [DATA_W-1:0]   r_d_hold;

    logic                w_issue;
    logic                w_grant_d;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_unused;

    // Only the word-address bits reach the RAM; the rest wrap silently.
    assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            StIdle: begin
                // Gated by reset so the RAM sees nothing while reset is held.
                if (!reset && (i_req || d_req)) begin
                    w_issue   = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    w_grant_d = d_req && (!i_req || !r_last_grant_d);
                    w_state_d = StWait;
                end
            end
            StWait: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_sel_addr = w_grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];

    assign mem_addr  = w_issue ? w_sel_addr : r_mem_addr;
    assign mem_we    = w_issue && w_grant_d && d_we;
    assign mem_wdata = d_wdata;
    assign busy      = (r_state == StWait);

    assign i_ready = (r_state == StWait) && !r_wait_d;
    assign d_ready = (r_state == StWait) && r_wait_d;

    // Pass RAM data straight through in the ready cycle, then serve from the hold.
    assign i_rdata = i_ready ? mem_rdata : r_i_hold;
    assign d_rdata = (d_ready && !r_wait_we) ? mem_rdata : r_d_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_last_grant_d <= 1'b0;
            r_wait_d       <= 1'b0;
            r_wait_we      <= 1'b0;
            r_mem_addr     <= '0;
            r_i_hold       <= '0;
            r_d_hold       <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_issue) begin
                r_last_grant_d <= w_grant_d;
                r_wait_d       <= w_grant_d;
                r_wait_we      <= mem_we;
                r_mem_addr     <= w_sel_addr;
            end
            if (i_ready) begin
                r_i_hold <= mem_rdata;
            end
            if (d_ready && !r_wait_we) begin
                r_d_hold <= mem_rdata;
            end
        end
    end

endmodule
